rps_spi_multi_rx: RTL and testbench
===================================

RPS_SPI_MULTI_RX -- requirements
Module: rps_spi_multi_rx

Interface
REQ-001 Parameter WIDTH, default 8, bits per SPI word (WIDTH >= 2).
REQ-002 Parameter NCH, default 2, words (player channels) per frame (NCH >= 1).
REQ-003 Parameters CODE_R / CODE_P / CODE_S, defaults 8'h52 / 8'h50 / 8'h53, WIDTH-bit move codes for rock / paper / scissors; they SHALL be pairwise distinct.
REQ-004 sck  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sdi  input  1  serial data, MSB first, sampled on rising sck.
REQ-007 cs  input  1  frame enable, active-high; bits count only while cs=1.
REQ-008 start  output  1  one-cycle pulse: first bit of a frame sampled.
REQ-009 done  output  1  one-cycle pulse: complete frame committed.
REQ-010 err  output  1  one-cycle pulse: frame aborted by cs falling mid-frame.
REQ-011 sig  output  NCH*WIDTH  last committed frame; channel k at sig[k*WIDTH +: WIDTH].
REQ-012 led  output  3*NCH  per-channel one-hot move; channel k at led[3k+:3], bit0 rock, bit1 paper, bit2 scissors.
REQ-013 invalid  output  NCH  bit k set when committed word k matches no move code.
REQ-014 result  output  2  channel 0 vs channel 1: 00 tie, 01 ch0 wins, 10 ch1 wins, 11 undecidable.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, HOLD; reset state IDLE.
REQ-016 IDLE, cs=1: sample sdi into shift register as bit WIDTH-1 of word 0, go SHIFT, assert start for the following cycle only.
REQ-017 IDLE, cs=0: no state change, no pulses.
REQ-018 SHIFT, cs=1: shift sdi in; bit counter counts 0..WIDTH-1, wraps to 0 and advances word counter after each full word.
REQ-019 Completed word k SHALL be written to shadow buffer slot k; committed outputs SHALL NOT change until the whole frame completes.
REQ-020 Edge sampling last bit of word NCH-1: sig, led, invalid, result SHALL all update at that edge (zero added latency); done high for the following cycle; go HOLD.
REQ-021 Decode: word == CODE_R/P/S -> led 001/010/100, invalid=0; otherwise led 000, invalid=1.
REQ-022 Result: paper beats rock, rock beats scissors, scissors beats paper; 11 if either channel 0 or 1 invalid; constant 11 when NCH=1.
REQ-023 SHIFT, cs=0 (any bit/word count): discard shadow buffer, clear counters, err high for one cycle, go IDLE; committed outputs hold.
REQ-024 HOLD, cs=1: further bits ignored, no pulses; HOLD, cs=0: go IDLE, no err.
REQ-025 A new frame SHALL require cs=0 for at least one sck edge after HOLD; back-to-back frames thereby lose no committed data.
REQ-026 start, done, err SHALL be registered and mutually exclusive in any cycle except start+done when WIDTH*NCH=1 (excluded by REQ-001).

Reset
REQ-027 reset=0 SHALL immediately force IDLE, counters 0, shadow buffer 0, start=done=err=0, sig=0, led=0, invalid all 1, result=11.
REQ-028 reset asserted mid-frame SHALL abort without err pulse; first frame after release starts from bit 0.

Verification (WIDTH=8, NCH=2 unless stated)
V-1 Reset, then cs=1, shift 0x52 then 0x53, cs=0 -> start 1 cycle after first edge; done 1 cycle after 16th edge; sig=0x5352, led=6'b100_001, invalid=00, result=01.
V-2 Frame 0x53,0x52 -> result=10; frame 0x50,0x50 -> result=00, led=6'b010_010.
V-3 Frame 0x52,0x41 -> invalid=10, led=6'b000_001, result=11.
V-4 Commit V-1 frame, then start new frame, drop cs after 11 bits -> err 1 cycle, no done, sig still 0x5352; next full frame commits normally.
V-5 After commit, hold cs=1 for 8 extra edges of 0xFF -> no pulses, outputs unchanged; cs=0 then new frame accepted.
V-6 Assert reset after 5 bits -> all outputs to REQ-027 values immediately, no err; NCH=3 build: frame 0x50,0x52,0x53 -> sig=0x535250, result=01.

Source files
------------

// File: rtl/rps_spi_multi_rx.sv
// SPI receiver for NCH rock/paper/scissors move words; commits a whole frame, decodes moves and judges ch0 vs ch1.
// Latency: outputs update on the edge sampling the last bit, done follows one cycle later; no backpressure, HOLD ignores excess bits.
module rps_spi_multi_rx #(
    parameter int              WIDTH  = 8,
    parameter int              NCH    = 2,
    parameter logic [WIDTH-1:0] CODE_R = WIDTH'(8'h52),
    parameter logic [WIDTH-1:0] CODE_P = WIDTH'(8'h50),
    parameter logic [WIDTH-1:0] CODE_S = WIDTH'(8'h53)
) (
    input  logic                   sck,
    input  logic                   reset,
    input  logic                   sdi,
    input  logic                   cs,
    output logic                   start,
    output logic                   done,
    output logic                   err,
    output logic [NCH*WIDTH-1:0]   sig,
    output logic [3*NCH-1:0]       led,
    output logic [NCH-1:0]         invalid,
    output logic [1:0]             result
);
    localparam int BC_W = $clog2(WIDTH);
    localparam int WC_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                       state_q, state_d;
    logic [BC_W-1:0]              bit_q, bit_d;
    logic [WC_W-1:0]              word_q, word_d;
    logic [WIDTH-1:0]             sr_q, sr_d, new_word;
    logic [NCH-1:0][WIDTH-1:0]    shadow_q, shadow_d, frame_c;
    logic                         start_q, start_d, done_q, done_d, err_q, err_d;
    logic [NCH*WIDTH-1:0]         sig_q, sig_d;
    logic [3*NCH-1:0]             led_q, led_d, dec_led;
    logic [NCH-1:0]               inv_q, inv_d, dec_inv;
    logic [1:0]                   res_q, res_d, dec_res;

    assign new_word = {sr_q[WIDTH-2:0], sdi};

    // Frame as it would look if the word now being finished were slotted in.
    always_comb begin
        frame_c = shadow_q;
        for (int k = 0; k < NCH; k++) begin
            if (word_q == WC_W'(k)) frame_c[k] = new_word;
        end
    end

    always_comb begin
        dec_led = '0;
        dec_inv = '1;
        for (int k = 0; k < NCH; k++) begin
            if (frame_c[k] == CODE_R) begin
                dec_led[3*k +: 3] = 3'b001;
                dec_inv[k]        = 1'b0;
            end else if (frame_c[k] == CODE_P) begin
                dec_led[3*k +: 3] = 3'b010;
                dec_inv[k]        = 1'b0;
            end else if (frame_c[k] == CODE_S) begin
                dec_led[3*k +: 3] = 3'b100;
                dec_inv[k]        = 1'b0;
            end
        end
    end

    generate
        if (NCH >= 2) begin : g_res
            logic [2:0] a, b;
            assign a = dec_led[2:0];
            assign b = dec_led[5:3];
            always_comb begin
                if (dec_inv[0] || dec_inv[1])                            dec_res = 2'b11;
                else if (a == b)                                         dec_res = 2'b00;
                else if ((a[1] & b[0]) | (a[0] & b[2]) | (a[2] & b[1])) dec_res = 2'b01;
                else                                                     dec_res = 2'b10;
            end
        end else begin : g_res_single
            assign dec_res = 2'b11;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        word_d   = word_q;
        sr_d     = sr_q;
        shadow_d = shadow_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        sig_d    = sig_q;
        led_d    = led_q;
        inv_d    = inv_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (cs) begin
                    sr_d    = {{(WIDTH-1){1'b0}}, sdi};
                    bit_d   = BC_W'(1);
                    word_d  = '0;
                    start_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!cs) begin
                    bit_d    = '0;
                    word_d   = '0;
                    sr_d     = '0;
                    shadow_d = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    sr_d = new_word;
                    if (bit_q == BC_W'(WIDTH-1)) begin
                        bit_d    = '0;
                        shadow_d = frame_c;
                        if (word_q == WC_W'(NCH-1)) begin
                            sig_d    = frame_c;
                            led_d    = dec_led;
                            inv_d    = dec_inv;
                            res_d    = dec_res;
                            done_d   = 1'b1;
                            word_d   = '0;
                            shadow_d = '0;
                            state_d  = HOLD;
                        end else begin
                            word_d = word_q + WC_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            word_q   <= '0;
            sr_q     <= '0;
            shadow_q <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sig_q    <= '0;
            led_q    <= '0;
            inv_q    <= '1;
            res_q    <= 2'b11;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            sr_q     <= sr_d;
            shadow_q <= shadow_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sig_q    <= sig_d;
            led_q    <= led_d;
            inv_q    <= inv_d;
            res_q    <= res_d;
        end
    end

    assign start   = start_q;
    assign done    = done_q;
    assign err     = err_q;
    assign sig     = sig_q;
    assign led     = led_q;
    assign invalid = inv_q;
    assign result  = res_q;
endmodule

// File: tb/tb_rps_spi_multi_rx.sv
// Directed bench for rps_spi_multi_rx: default 2-channel build plus a 3-channel build.
module tb_rps_spi_multi_rx;
    logic        sck = 1'b0;
    logic        reset, sdi, cs, sdi3, cs3;
    logic        start, done, err, start3, done3, err3;
    logic [15:0] sig;
    logic [5:0]  led;
    logic [1:0]  invalid, result, res3;
    logic [23:0] sig3;
    logic [8:0]  led3;
    logic [2:0]  inv3;

    int compared = 0, mismatched = 0;
    int n_start, n_done, n_err, start_at, done_at, err_at;

    rps_spi_multi_rx dut (
        .sck(sck), .reset(reset), .sdi(sdi), .cs(cs),
        .start(start), .done(done), .err(err),
        .sig(sig), .led(led), .invalid(invalid), .result(result)
    );

    rps_spi_multi_rx #(.NCH(3)) dut3 (
        .sck(sck), .reset(reset), .sdi(sdi3), .cs(cs3),
        .start(start3), .done(done3), .err(err3),
        .sig(sig3), .led(led3), .invalid(inv3), .result(res3)
    );

    always #5 sck = ~sck;

    task automatic clr_cnt();
        n_start = 0; n_done = 0; n_err = 0;
        start_at = -1; done_at = -1; err_at = -1;
    endtask

    // Drive at the falling edge, observe the registered result at the next falling edge.
    task automatic tick(input logic c, input logic d, input int idx);
        cs = c; sdi = d;
        @(posedge sck);
        @(negedge sck);
        if (start) begin n_start++; start_at = idx; end
        if (done)  begin n_done++;  done_at  = idx; end
        if (err)   begin n_err++;   err_at   = idx; end
    endtask

    task automatic drive_bits(input logic [23:0] bits, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, bits[n-1-i], i);
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, i);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b0; sdi = 1'b0; cs3 = 1'b0; sdi3 = 1'b0;
        #1 reset = 1'b0;
        #1;
        compared++; if ({start, done, err} !== 3'b000) begin mismatched++; $display("FAIL rst_pulses: got %b want 000", {start, done, err}); end
        compared++; if (sig !== 16'h0000) begin mismatched++; $display("FAIL rst_sig: got %h want 0000", sig); end
        compared++; if (led !== 6'b000000) begin mismatched++; $display("FAIL rst_led: got %b want 000000", led); end
        compared++; if (invalid !== 2'b11) begin mismatched++; $display("FAIL rst_invalid: got %b want 11", invalid); end
        compared++; if (result !== 2'b11) begin mismatched++; $display("FAIL rst_result: got %b want 11", result); end
        @(negedge sck);
        reset = 1'b1;
        clr_cnt();
        drive_idle(3);
        compared++; if (n_start + n_done + n_err !== 0) begin mismatched++; $display("FAIL idle_pulses: got %0d want 0", n_start + n_done + n_err); end
    endtask

    task automatic test_basic_frame();
        clr_cnt();
        drive_bits({8'h52, 8'h53}, 16);
        compared++; if (start_at !== 0 || n_start !== 1) begin mismatched++; $display("FAIL v1_start: got at %0d x%0d want at 0 x1", start_at, n_start); end
        compared++; if (done_at !== 15 || n_done !== 1) begin mismatched++; $display("FAIL v1_done: got at %0d x%0d want at 15 x1", done_at, n_done); end
        compared++; if (n_err !== 0) begin mismatched++; $display("FAIL v1_err: got %0d want 0", n_err); end
        compared++; if (sig !== 16'h5352) begin mismatched++; $display("FAIL v1_sig: got %h want 5352", sig); end
        compared++; if (led !== 6'b100_001) begin mismatched++; $display("FAIL v1_led: got %b want 100001", led); end
        compared++; if (invalid !== 2'b00) begin mismatched++; $display("FAIL v1_invalid: got %b want 00", invalid); end
        compared++; if (result !== 2'b01) begin mismatched++; $display("FAIL v1_result: got %b want 01", result); end
        clr_cnt();
        drive_idle(1);
        compared++; if (n_done + n_err !== 0) begin mismatched++; $display("FAIL v1_after: got %0d pulses want 0", n_done + n_err); end
    endtask

    task automatic test_results();
        drive_bits({8'h53, 8'h52}, 16);
        compared++; if (result !== 2'b10) begin mismatched++; $display("FAIL v2_sr_result: got %b want 10", result); end
        compared++; if (led !== 6'b001_100) begin mismatched++; $display("FAIL v2_sr_led: got %b want 001100", led); end
        drive_idle(1);
        drive_bits({8'h50, 8'h50}, 16);
        compared++; if (result !== 2'b00) begin mismatched++; $display("FAIL v2_pp_result: got %b want 00", result); end
        compared++; if (led !== 6'b010_010) begin mismatched++; $display("FAIL v2_pp_led: got %b want 010010", led); end
        drive_idle(1);
    endtask

    task automatic test_invalid();
        drive_bits({8'h52, 8'h41}, 16);
        compared++; if (invalid !== 2'b10) begin mismatched++; $display("FAIL v3_invalid: got %b want 10", invalid); end
        compared++; if (led !== 6'b000_001) begin mismatched++; $display("FAIL v3_led: got %b want 000001", led); end
        compared++; if (result !== 2'b11) begin mismatched++; $display("FAIL v3_result: got %b want 11", result); end
        drive_idle(1);
        drive_bits({8'h00, 8'h50}, 16);
        compared++; if (invalid !== 2'b01 || led !== 6'b010_000) begin mismatched++; $display("FAIL v3b_decode: got inv %b led %b want 01 010000", invalid, led); end
        compared++; if (result !== 2'b11) begin mismatched++; $display("FAIL v3b_result: got %b want 11", result); end
        drive_idle(1);
    endtask

    task automatic test_abort();
        drive_bits({8'h52, 8'h53}, 16);
        drive_idle(1);
        clr_cnt();
        drive_bits({8'h50, 8'h52}, 11);
        compared++; if (sig !== 16'h5352 || n_done !== 0) begin mismatched++; $display("FAIL v4_midframe: got sig %h done %0d want 5352 0", sig, n_done); end
        clr_cnt();
        drive_idle(1);
        compared++; if (n_err !== 1 || err_at !== 0) begin mismatched++; $display("FAIL v4_err: got x%0d at %0d want x1 at 0", n_err, err_at); end
        clr_cnt();
        drive_idle(1);
        compared++; if (n_err !== 0 || n_done !== 0) begin mismatched++; $display("FAIL v4_err_len: got err %0d done %0d want 0 0", n_err, n_done); end
        compared++; if (sig !== 16'h5352 || result !== 2'b01) begin mismatched++; $display("FAIL v4_hold: got %h %b want 5352 01", sig, result); end
        clr_cnt();
        drive_bits({8'h50, 8'h52}, 16);
        compared++; if (sig !== 16'h5250 || result !== 2'b01 || done_at !== 15) begin mismatched++; $display("FAIL v4_next: got %h %b done@%0d want 5250 01 15", sig, result, done_at); end
        drive_idle(1);
    endtask

    task automatic test_back_to_back();
        drive_bits({8'h50, 8'h53}, 16);
        clr_cnt();
        drive_bits(24'hFF, 8);
        compared++; if (n_start + n_done + n_err !== 0) begin mismatched++; $display("FAIL v5_hold_pulses: got %0d want 0", n_start + n_done + n_err); end
        compared++; if (sig !== 16'h5350 || led !== 6'b100_010 || result !== 2'b10) begin mismatched++; $display("FAIL v5_hold_out: got %h %b %b want 5350 100010 10", sig, led, result); end
        clr_cnt();
        drive_idle(1);
        compared++; if (n_err !== 0) begin mismatched++; $display("FAIL v5_release_err: got %0d want 0", n_err); end
        clr_cnt();
        drive_bits({8'h53, 8'h50}, 16);
        compared++; if (start_at !== 0 || done_at !== 15) begin mismatched++; $display("FAIL v5_next_pulses: got start@%0d done@%0d want 0 15", start_at, done_at); end
        compared++; if (sig !== 16'h5053 || result !== 2'b01) begin mismatched++; $display("FAIL v5_next_out: got %h %b want 5053 01", sig, result); end
        drive_idle(1);
    endtask

    task automatic test_reset_mid_frame();
        clr_cnt();
        drive_bits(24'h0A, 5);
        #2 reset = 1'b0;
        #1;
        compared++; if (sig !== 16'h0000 || led !== 6'b0 || {start, done, err} !== 3'b000) begin mismatched++; $display("FAIL v6_rst_out: got %h %b %b want 0000 000000 000", sig, led, {start, done, err}); end
        compared++; if (invalid !== 2'b11 || result !== 2'b11) begin mismatched++; $display("FAIL v6_rst_dec: got %b %b want 11 11", invalid, result); end
        @(negedge sck);
        cs = 1'b0;
        reset = 1'b1;
        clr_cnt();
        drive_idle(2);
        compared++; if (n_err !== 0) begin mismatched++; $display("FAIL v6_no_err: got %0d want 0", n_err); end
        clr_cnt();
        drive_bits({8'h52, 8'h53}, 16);
        compared++; if (sig !== 16'h5352 || done_at !== 15) begin mismatched++; $display("FAIL v6_restart: got %h done@%0d want 5352 15", sig, done_at); end
        drive_idle(1);
    endtask

    task automatic test_nch3();
        logic [23:0] bits;
        int d3_at;
        bits = {8'h50, 8'h52, 8'h53};
        d3_at = -1;
        for (int i = 0; i < 24; i++) begin
            cs3 = 1'b1; sdi3 = bits[23-i];
            @(posedge sck);
            @(negedge sck);
            if (done3) d3_at = i;
        end
        cs3 = 1'b0;
        compared++; if (d3_at !== 23) begin mismatched++; $display("FAIL n3_done: got at %0d want 23", d3_at); end
        compared++; if (sig3 !== 24'h535250) begin mismatched++; $display("FAIL n3_sig: got %h want 535250", sig3); end
        compared++; if (res3 !== 2'b01 || inv3 !== 3'b000) begin mismatched++; $display("FAIL n3_res: got %b %b want 01 000", res3, inv3); end
        compared++; if (led3 !== 9'b100_001_010) begin mismatched++; $display("FAIL n3_led: got %b want 100001010", led3); end
        @(negedge sck);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_results();
        test_invalid();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_nch3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
